hazard_scoreboard: RTL and testbench

Parametrised successor to the ID-stage stall detector for the pipelined RISC-V core. The old detector compared ID sources only against the EX and MEM destinations. This block replaces that with a per-register scoreboard of countdown timers. It covers fixed-latency producers with and without forwarding, and variable-latency producers such as cache-miss loads and a multi-cycle mul/div, which hold a register until an explicit completion arrives. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: one countdown timer per architectural register, stall
// generation for sources that are still in flight, and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int CNT_W      = 3,
  parameter int FORWARD_EN = 1,
  parameter int NOFWD_LAT  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_rs1,
  input  logic [ADDR_W-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                id_reg_write,
  input  logic [ADDR_W-1:0]   id_rd,
  input  logic [CNT_W-1:0]    id_lat,
  input  logic                flush,
  input  logic                hold,
  input  logic                done_valid,
  input  logic [ADDR_W-1:0]   done_rd,
  output logic                is_stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [31:0]         stall_count
);

  localparam logic [CNT_W-1:0] LAT_UNKNOWN = '1;
  localparam logic [CNT_W-1:0] NOFWD_CNT   = CNT_W'(NOFWD_LAT);

  logic [CNT_W-1:0] timer [1:NUM_REGS-1];
  logic [CNT_W-1:0] lat_eff;
  logic             src_hit_1;
  logic             src_hit_2;
  logic             issue;

  // Index decode through the mask so an index beyond NUM_REGS-1 reads as not busy.
  function automatic logic reg_busy(input logic [ADDR_W-1:0] idx,
                                    input logic [NUM_REGS-1:0] mask);
    reg_busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++)
      if (idx == ADDR_W'(r)) reg_busy = mask[r];
  endfunction

  always_comb begin
    if (FORWARD_EN != 0)
      lat_eff = id_lat;
    else if (id_lat == LAT_UNKNOWN)
      lat_eff = LAT_UNKNOWN;
    else
      lat_eff = NOFWD_CNT;
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++)
      busy_mask[r] = (timer[r] != '0);
  end

  assign src_hit_1 = id_use_rs1 && (id_rs1 != '0) && reg_busy(id_rs1, busy_mask);
  assign src_hit_2 = id_use_rs2 && (id_rs2 != '0) && reg_busy(id_rs2, busy_mask);
  assign is_stall  = id_valid && (src_hit_1 || src_hit_2);
  assign issue     = id_valid && !is_stall && !flush && !hold && id_reg_write &&
                     (id_rd != '0) && (lat_eff != '0);

  // Priority: new issue, then completion (even under hold), then countdown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 1; r < NUM_REGS; r++)
        timer[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue && (id_rd == ADDR_W'(r)))
          timer[r] <= lat_eff;
        else if ((timer[r] == LAT_UNKNOWN) && done_valid && (done_rd == ADDR_W'(r)))
          timer[r] <= '0;
        else if ((timer[r] != '0) && (timer[r] != LAT_UNKNOWN) && !hold)
          timer[r] <= timer[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_count <= '0;
    else if (is_stall && !hold && (stall_count != 32'hFFFF_FFFF))
      stall_count <= stall_count + 32'd1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a forwarding instance and a no-forward instance share
// the stimulus; per-cycle expectations are queued on drive and popped mid-cycle.
module tb_hazard_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                id_valid;
  logic [ADDR_W-1:0]   id_rs1;
  logic [ADDR_W-1:0]   id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic                id_reg_write;
  logic [ADDR_W-1:0]   id_rd;
  logic [CNT_W-1:0]    id_lat;
  logic                flush;
  logic                hold;
  logic                done_valid;
  logic [ADDR_W-1:0]   done_rd;
  logic                is_stall;
  logic [NUM_REGS-1:0] busy_mask;
  logic [31:0]         stall_count;
  logic                nf_is_stall;
  logic [NUM_REGS-1:0] nf_busy_mask;
  logic [31:0]         nf_stall_count;

  typedef struct {
    string tag;
    logic  stall;
    int    idx;
    logic  busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
                      .FORWARD_EN(1), .NOFWD_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_reg_write(id_reg_write),
    .id_rd(id_rd), .id_lat(id_lat), .flush(flush), .hold(hold), .done_valid(done_valid),
    .done_rd(done_rd), .is_stall(is_stall), .busy_mask(busy_mask), .stall_count(stall_count)
  );

  hazard_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
                      .FORWARD_EN(0), .NOFWD_LAT(2)) dut_nf (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_reg_write(id_reg_write),
    .id_rd(id_rd), .id_lat(id_lat), .flush(flush), .hold(hold), .done_valid(done_valid),
    .done_rd(done_rd), .is_stall(nf_is_stall), .busy_mask(nf_busy_mask),
    .stall_count(nf_stall_count)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1, "timeout");
  end

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_reg_write = 1'b0; id_rd = '0; id_lat = '0;
    flush = 1'b0; hold = 1'b0; done_valid = 1'b0; done_rd = '0;
  endtask

  task automatic instr(input int rs1, input int u1, input int rs2, input int u2,
                       input int we, input int rd, input int lat);
    id_valid     = 1'b1;
    id_rs1       = ADDR_W'(rs1);
    id_use_rs1   = (u1 != 0);
    id_rs2       = ADDR_W'(rs2);
    id_use_rs2   = (u2 != 0);
    id_reg_write = (we != 0);
    id_rd        = ADDR_W'(rd);
    id_lat       = CNT_W'(lat);
  endtask

  task automatic expect_cyc(input string tag, input int stall, input int idx, input int busy);
    exp_t e;
    e.tag   = tag;
    e.stall = (stall != 0);
    e.idx   = idx;
    e.busy  = (busy != 0);
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    next_cycle();
    n_checks++;
    if (busy_mask !== '0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
    n_checks++;
    if (is_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", is_stall); end
    n_checks++;
    if (stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", stall_count); end
    reset_n = 1'b1;
    instr(0, 0, 0, 0, 1, 5, 7);
    next_cycle();
    instr(5, 1, 0, 0, 1, 6, 0);
    @(negedge clk);
    n_checks++;
    if (is_stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall: got %b want 1", is_stall); end
    n_checks++;
    if (busy_mask[5] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy5: got %b want 1", busy_mask[5]); end
    next_cycle();
    n_checks++;
    if (stall_count !== 32'd1) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 1", stall_count); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy_mask !== '0) begin n_fail++; $display("FAIL midrun_reset_busy: got %h want 0", busy_mask); end
    n_checks++;
    if (is_stall !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_stall: got %b want 0", is_stall); end
    n_checks++;
    if (stall_count !== 32'd0) begin n_fail++; $display("FAIL midrun_reset_count: got %0d want 0", stall_count); end
    next_cycle();
    reset_n = 1'b1;
    idle();
  endtask

  task automatic test_load_use();
    exp_t e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      case (c)
        0: begin instr(0, 0, 0, 0, 1, 5, 1); expect_cyc("load_use c0", 0, 5, 0); end
        1: begin instr(5, 1, 0, 1, 1, 6, 0); expect_cyc("load_use c1", 1, 5, 1); end
        2: begin instr(5, 1, 0, 1, 1, 6, 0); expect_cyc("load_use c2", 0, 5, 0); end
        3: begin instr(0, 0, 0, 0, 1, 7, 0); expect_cyc("alu_dep c3", 0, 7, 0); end
        default: begin instr(7, 1, 0, 0, 1, 8, 0); expect_cyc("alu_dep c4", 0, 7, 0); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (is_stall !== e.stall) begin n_fail++; $display("FAIL %s is_stall: got %b want %b", e.tag, is_stall, e.stall); end
      n_checks++;
      if (busy_mask[e.idx] !== e.busy) begin n_fail++; $display("FAIL %s busy_mask[%0d]: got %b want %b", e.tag, e.idx, busy_mask[e.idx], e.busy); end
      next_cycle();
    end
    idle();
    n_checks++;
    if (stall_count !== 32'd1) begin n_fail++; $display("FAIL load_use_count: got %0d want 1", stall_count); end
    n_checks++;
    if (busy_mask !== '0) begin n_fail++; $display("FAIL load_use_idle_busy: got %h want 0", busy_mask); end
  endtask

  task automatic test_no_forward();
    exp_t e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      case (c)
        0: begin instr(0, 0, 0, 0, 1, 7, 0); expect_cyc("nofwd c0", 0, 7, 0); end
        1: begin instr(7, 1, 7, 1, 1, 8, 0); expect_cyc("nofwd c1", 1, 7, 1); end
        2: begin instr(7, 1, 7, 1, 1, 8, 0); expect_cyc("nofwd c2", 1, 7, 1); end
        3: begin instr(7, 1, 7, 1, 1, 8, 0); expect_cyc("nofwd c3", 0, 7, 0); end
        default: begin instr(0, 1, 8, 0, 1, 9, 0); expect_cyc("nofwd_unused_rs2 c4", 0, 8, 1); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (nf_is_stall !== e.stall) begin n_fail++; $display("FAIL %s is_stall: got %b want %b", e.tag, nf_is_stall, e.stall); end
      n_checks++;
      if (nf_busy_mask[e.idx] !== e.busy) begin n_fail++; $display("FAIL %s busy_mask[%0d]: got %b want %b", e.tag, e.idx, nf_busy_mask[e.idx], e.busy); end
      next_cycle();
    end
    idle();
    n_checks++;
    if (nf_stall_count !== 32'd2) begin n_fail++; $display("FAIL nofwd_count: got %0d want 2", nf_stall_count); end
    n_checks++;
    if (stall_count !== 32'd0) begin n_fail++; $display("FAIL fwd_alu_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_variable_latency();
    exp_t e;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      idle();
      if (c == 0) begin
        instr(0, 0, 0, 0, 1, 9, 7);
        expect_cyc("varlat c0", 0, 9, 0);
      end else begin
        instr(9, 1, 0, 0, 1, 10, 0);
        done_valid = (c == 4) || (c == 11);
        done_rd    = (c == 4) ? 5'd10 : 5'd9;
        expect_cyc($sformatf("varlat c%0d", c), (c <= 11) ? 1 : 0, 9, (c <= 11) ? 1 : 0);
      end
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (is_stall !== e.stall) begin n_fail++; $display("FAIL %s is_stall: got %b want %b", e.tag, is_stall, e.stall); end
      n_checks++;
      if (busy_mask[e.idx] !== e.busy) begin n_fail++; $display("FAIL %s busy_mask[%0d]: got %b want %b", e.tag, e.idx, busy_mask[e.idx], e.busy); end
      next_cycle();
    end
    idle();
    n_checks++;
    if (stall_count !== 32'd11) begin n_fail++; $display("FAIL varlat_count: got %0d want 11", stall_count); end
    n_checks++;
    if (busy_mask !== '0) begin n_fail++; $display("FAIL varlat_idle_busy: got %h want 0", busy_mask); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle();
      case (c)
        0: begin instr(0, 0, 0, 0, 1, 4, 1); expect_cyc("simul c0", 0, 4, 0); end
        1: begin instr(0, 0, 0, 0, 1, 4, 1); expect_cyc("simul_reissue c1", 0, 4, 1); end
        2: begin expect_cyc("simul_override c2", 0, 4, 1); end
        3: begin instr(0, 0, 0, 0, 1, 4, 7); expect_cyc("simul c3", 0, 4, 0); end
        4: begin instr(0, 0, 0, 0, 1, 4, 7); done_valid = 1'b1; done_rd = 5'd4; expect_cyc("simul_done_issue c4", 0, 4, 1); end
        5: begin instr(4, 1, 0, 0, 0, 0, 0); done_valid = 1'b1; done_rd = 5'd4; expect_cyc("simul_issue_wins c5", 1, 4, 1); end
        default: begin instr(4, 1, 0, 0, 0, 0, 0); expect_cyc("simul_done c6", 0, 4, 0); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (is_stall !== e.stall) begin n_fail++; $display("FAIL %s is_stall: got %b want %b", e.tag, is_stall, e.stall); end
      n_checks++;
      if (busy_mask[e.idx] !== e.busy) begin n_fail++; $display("FAIL %s busy_mask[%0d]: got %b want %b", e.tag, e.idx, busy_mask[e.idx], e.busy); end
      next_cycle();
    end
    idle();
    n_checks++;
    if (stall_count !== 32'd1) begin n_fail++; $display("FAIL simul_count: got %0d want 1", stall_count); end
  endtask

  task automatic test_hold_flush();
    exp_t e;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      idle();
      case (c)
        0: begin instr(0, 0, 0, 0, 1, 3, 2); expect_cyc("hold c0", 0, 3, 0); end
        1, 2, 3: begin instr(3, 1, 0, 0, 1, 14, 0); hold = 1'b1; expect_cyc($sformatf("hold c%0d", c), 1, 3, 1); end
        4, 5: begin instr(3, 1, 0, 0, 1, 14, 0); expect_cyc($sformatf("hold_release c%0d", c), 1, 3, 1); end
        6: begin instr(3, 1, 0, 0, 1, 14, 0); expect_cyc("hold_release c6", 0, 3, 0); end
        7: begin instr(0, 0, 0, 0, 1, 11, 1); flush = 1'b1; expect_cyc("flush c7", 0, 11, 0); end
        8: begin expect_cyc("flush c8", 0, 11, 0); end
        9: begin instr(0, 0, 0, 0, 1, 0, 7); expect_cyc("x0_write c9", 0, 0, 0); end
        10: begin instr(0, 1, 0, 1, 0, 0, 0); expect_cyc("x0_read c10", 0, 0, 0); end
        11: begin instr(0, 0, 0, 0, 1, 13, 1); hold = 1'b1; expect_cyc("hold_issue c11", 0, 13, 0); end
        12: begin expect_cyc("hold_issue c12", 0, 13, 0); end
        13: begin instr(0, 0, 0, 0, 1, 12, 7); expect_cyc("hold_done c13", 0, 12, 0); end
        14: begin hold = 1'b1; done_valid = 1'b1; done_rd = 5'd12; expect_cyc("hold_done c14", 0, 12, 1); end
        default: begin expect_cyc("hold_done c15", 0, 12, 0); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (is_stall !== e.stall) begin n_fail++; $display("FAIL %s is_stall: got %b want %b", e.tag, is_stall, e.stall); end
      n_checks++;
      if (busy_mask[e.idx] !== e.busy) begin n_fail++; $display("FAIL %s busy_mask[%0d]: got %b want %b", e.tag, e.idx, busy_mask[e.idx], e.busy); end
      if (c == 4) begin
        n_checks++;
        if (stall_count !== 32'd0) begin n_fail++; $display("FAIL hold_count_frozen: got %0d want 0", stall_count); end
      end
      next_cycle();
    end
    idle();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL hold_count_final: got %0d want 2", stall_count); end
    n_checks++;
    if (busy_mask !== '0) begin n_fail++; $display("FAIL hold_idle_busy: got %h want 0", busy_mask); end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_forward();
    test_variable_latency();
    test_simultaneous();
    test_hold_flush();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
